// File: rtl/spi_bus_bridge_if.sv
// Bundle of the SPI byte stream and the parallel bus seen by spi_bus_bridge.
// master: the bridge side; slave: the SPI front end plus the bus target.
interface spi_bus_bridge_if #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int NUM_TARGET = 4
);
  logic                  rx_rst;
  logic [7:0]            rx_data;
  logic                  rx_pop;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic [NUM_TARGET-1:0] bus_sel;
  logic [ADDR_W-1:0]     bus_addr;
  logic                  bus_we;
  logic                  bus_req;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_ack;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    input  rx_rst, rx_data, rx_pop, bus_ack, bus_rdata,
    output tx_data, tx_valid, bus_sel, bus_addr, bus_we, bus_req, bus_wdata
  );

  modport slave (
    output rx_rst, rx_data, rx_pop, bus_ack, bus_rdata,
    input  tx_data, tx_valid, bus_sel, bus_addr, bus_we, bus_req, bus_wdata
  );
endinterface

// File: rtl/spi_bus_bridge.sv
// SPI-to-bus bridge: a command byte, address bytes and data bytes drive bus reads/writes.
// Define SPI_BUS_BRIDGE_AUTOINC_EN to post-increment bus_addr after every bus_ack.
module spi_bus_bridge #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 4,
  parameter int NUM_TARGET = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_bus_bridge_if.master bif
);
  localparam int ADDR_W = 4 + 8 * ADDR_BYTES;
  localparam int LOW_W  = 8 * ADDR_BYTES;
  localparam int DATA_W = 8 * DATA_BYTES;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_BUS     = 3'd3;
  localparam logic [2:0] S_RDATA   = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [NUM_TARGET-1:0] sel_q, sel_d;
  logic                  cmd_we_q, cmd_we_d;
  logic                  bus_we_q, bus_we_d;
  logic                  req_q, req_d;
  logic                  abort_q, abort_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  dfr_vld_q, dfr_vld_d;
  logic [7:0]            dfr_data_q, dfr_data_d;

  logic                  rsp_vld;
  logic [7:0]            rsp_data;
  logic [NUM_TARGET-1:0] sel_dec;
  logic                  cmd_ok;
  logic [2:0]            cmd_idx;

  assign cmd_idx = bif.rx_data[6:4];

  // Indices at or above NUM_TARGET decode to all-zero, which flags the command as invalid.
  for (genvar gi = 0; gi < NUM_TARGET; gi++) begin : g_sel
    assign sel_dec[gi] = (cmd_idx == 3'(gi));
  end
  assign cmd_ok = |sel_dec;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    sel_d      = sel_q;
    cmd_we_d   = cmd_we_q;
    bus_we_d   = bus_we_q;
    req_d      = req_q;
    abort_d    = abort_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    dfr_vld_d  = dfr_vld_q;
    dfr_data_d = dfr_data_q;
    rsp_vld    = 1'b0;
    rsp_data   = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (bif.rx_pop) begin
          cmd_we_d = bif.rx_data[7];
          sel_d    = sel_dec;
          addr_d   = {bif.rx_data[3:0], LOW_W'(0)};
          cnt_d    = 3'd0;
          rsp_vld  = 1'b1;
          if (cmd_ok) begin
            rsp_data = 8'hCC;
            state_d  = S_ADDR;
          end else begin
            rsp_data = 8'hEE;
            state_d  = S_DISCARD;
          end
        end
      end
      S_ADDR: begin
        if (bif.rx_pop) begin
          addr_d   = {addr_q[ADDR_W-1 -: 4], (addr_q[LOW_W-1:0] << 8) | LOW_W'(bif.rx_data)};
          cnt_d    = cnt_q + 3'd1;
          rsp_vld  = 1'b1;
          rsp_data = 8'hAD;
          if (cnt_q == 3'(ADDR_BYTES - 1)) begin
            cnt_d = 3'd0;
            if (cmd_we_q) begin
              state_d = S_WDATA;
            end else begin
              state_d  = S_BUS;
              req_d    = 1'b1;
              bus_we_d = 1'b0;
            end
          end
        end
      end
      S_WDATA: begin
        if (bif.rx_pop) begin
          wdata_d  = (wdata_q << 8) | DATA_W'(bif.rx_data);
          cnt_d    = cnt_q + 3'd1;
          rsp_vld  = 1'b1;
          rsp_data = {4'hD, 2'b00, cnt_q[1:0]};
          if (cnt_q == 3'(DATA_BYTES - 1)) begin
            cnt_d    = 3'd0;
            state_d  = S_BUS;
            req_d    = 1'b1;
            bus_we_d = 1'b1;
          end
        end
      end
      S_BUS: begin
        if (req_q && bif.bus_ack) begin
          req_d = 1'b0;
          cnt_d = 3'd0;
`ifdef SPI_BUS_BRIDGE_AUTOINC_EN
          addr_d = addr_q + ADDR_W'(1);
`else
          addr_d = addr_q;
`endif
          if (abort_q || bif.rx_rst) begin
            abort_d = 1'b0;
            state_d = S_IDLE;
          end else if (bus_we_q) begin
            state_d = S_WDATA;
          end else begin
            rsp_vld  = 1'b1;
            rsp_data = bif.bus_rdata[DATA_W-1 -: 8];
            rdata_d  = bif.bus_rdata << 8;
            cnt_d    = 3'd1;
            state_d  = S_RDATA;
          end
        end else if (bif.rx_rst) begin
          abort_d = 1'b1;
        end
      end
      S_RDATA: begin
        if (bif.rx_pop) begin
          if (cnt_q == 3'(DATA_BYTES)) begin
            cnt_d    = 3'd0;
            state_d  = S_BUS;
            req_d    = 1'b1;
            bus_we_d = 1'b0;
          end else begin
            rsp_vld  = 1'b1;
            rsp_data = rdata_q[DATA_W-1 -: 8];
            rdata_d  = rdata_q << 8;
            cnt_d    = cnt_q + 3'd1;
          end
        end
      end
      S_DISCARD: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A bus cycle in flight must complete, so frame abort outside BUS is immediate.
    if (bif.rx_rst && state_q != S_BUS) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      rsp_vld = 1'b0;
    end

    // One-deep deferral keeps tx_valid from pulsing on consecutive cycles.
    if (!tx_valid_q && dfr_vld_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = dfr_data_q;
      dfr_vld_d  = rsp_vld;
      dfr_data_d = rsp_data;
    end else if (!tx_valid_q && rsp_vld) begin
      tx_valid_d = 1'b1;
      tx_data_d  = rsp_data;
    end else if (rsp_vld) begin
      dfr_vld_d  = 1'b1;
      dfr_data_d = rsp_data;
    end

    if (bif.rx_rst) begin
      dfr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      sel_q      <= '0;
      cmd_we_q   <= 1'b0;
      bus_we_q   <= 1'b0;
      req_q      <= 1'b0;
      abort_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      dfr_vld_q  <= 1'b0;
      dfr_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      sel_q      <= sel_d;
      cmd_we_q   <= cmd_we_d;
      bus_we_q   <= bus_we_d;
      req_q      <= req_d;
      abort_q    <= abort_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      dfr_vld_q  <= dfr_vld_d;
      dfr_data_q <= dfr_data_d;
    end
  end

  assign bif.tx_data   = tx_data_q;
  assign bif.tx_valid  = tx_valid_q;
  assign bif.bus_sel   = sel_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_we    = bus_we_q;
  assign bif.bus_req   = req_q;
  assign bif.bus_wdata = wdata_q;
endmodule

// File: tb/tb_spi_bus_bridge.sv
// Self-checking bench for spi_bus_bridge: frame tables feed a tx-byte scoreboard,
// hand-written sequences cover bus handshake, discard, abort-in-BUS and reset.
module tb_spi_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_bus_bridge_if #(.ADDR_W(20), .DATA_W(32), .NUM_TARGET(4)) bif ();

  spi_bus_bridge #(.ADDR_BYTES(2), .DATA_BYTES(4), .NUM_TARGET(4)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  typedef struct {
    logic [7:0] rx;
    logic       has_tx;
    logic [7:0] tx;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       prev_tx = 1'b0;
  logic       req_allowed = 1'b1;

`ifdef SPI_BUS_BRIDGE_AUTOINC_EN
  localparam logic [19:0] RD2_ADDR  = 20'h10011;
  localparam logic [19:0] WRAP_ADDR = 20'h00000;
`else
  localparam logic [19:0] RD2_ADDR  = 20'h10010;
  localparam logic [19:0] WRAP_ADDR = 20'hFFFFF;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Every clock step goes through here, so the tx scoreboard sees every cycle.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (bif.tx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got 0x%0h expected no tx byte", bif.tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", bif.tx_data, e);
      end
      chk("tx_not_back_to_back", prev_tx, 1'b0);
    end
    if (!req_allowed) begin
      checks++;
      if (bif.bus_req !== 1'b0) begin
        errors++;
        $display("FAIL no_bus_req: got %b expected 0", bif.bus_req);
      end
    end
    prev_tx = bif.tx_valid;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic has_tx, input logic [7:0] t);
    if (has_tx) exp_q.push_back(t);
    bif.rx_data = b;
    bif.rx_pop  = 1'b1;
    tick();
    bif.rx_pop  = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].rx, vecs[i].has_tx, vecs[i].tx);
    end
    vecs.delete();
  endtask

  task automatic frame_abort();
    bif.rx_rst = 1'b1;
    tick();
    bif.rx_rst = 1'b0;
    tick();
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !bif.bus_req; i++) tick();
    chk("bus_req_seen", bif.bus_req, 1'b1);
  endtask

  // Holds off the ack for 'delay' cycles, checking the request stays up, then acks once.
  task automatic do_ack(input logic [31:0] rdata, input int delay);
    logic held = 1'b1;
    for (int i = 0; i < delay; i++) begin
      if (bif.bus_req !== 1'b1) held = 1'b0;
      tick();
    end
    chk("bus_req_held", held, 1'b1);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = rdata;
    tick();
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'h0;
    chk("bus_req_dropped", bif.bus_req, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, bif.tx_valid, 1'b0);
    chk({tag, "_tx_data"}, bif.tx_data, 8'h00);
    chk({tag, "_bus_req"}, bif.bus_req, 1'b0);
    chk({tag, "_bus_we"}, bif.bus_we, 1'b0);
    chk({tag, "_bus_sel"}, bif.bus_sel, 4'b0000);
    chk({tag, "_bus_addr"}, bif.bus_addr, 20'h0);
    chk({tag, "_bus_wdata"}, bif.bus_wdata, 32'h0);
  endtask

  initial begin
    bif.rx_rst    = 1'b0;
    bif.rx_data   = 8'h00;
    bif.rx_pop    = 1'b0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'h0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Write 0xDEADBEEF to target 1, address 0x12345.
    vecs.push_back('{8'h91, 1'b1, 8'hCC});
    vecs.push_back('{8'h23, 1'b1, 8'hAD});
    vecs.push_back('{8'h45, 1'b1, 8'hAD});
    vecs.push_back('{8'hDE, 1'b1, 8'hD0});
    vecs.push_back('{8'hAD, 1'b1, 8'hD1});
    vecs.push_back('{8'hBE, 1'b1, 8'hD2});
    vecs.push_back('{8'hEF, 1'b1, 8'hD3});
    run_vecs();
    wait_req();
    chk("wr_sel", bif.bus_sel, 4'b0010);
    chk("wr_addr", bif.bus_addr, 20'h12345);
    chk("wr_we", bif.bus_we, 1'b1);
    chk("wr_wdata", bif.bus_wdata, 32'hDEADBEEF);
    do_ack(32'h0, 2);
    send_byte(8'h11, 1'b1, 8'hD0);
    frame_abort();

    // Read from target 2, address 0x10010, then a follow-on read.
    vecs.push_back('{8'h21, 1'b1, 8'hCC});
    vecs.push_back('{8'h00, 1'b1, 8'hAD});
    vecs.push_back('{8'h10, 1'b1, 8'hAD});
    run_vecs();
    wait_req();
    chk("rd_sel", bif.bus_sel, 4'b0100);
    chk("rd_addr", bif.bus_addr, 20'h10010);
    chk("rd_we", bif.bus_we, 1'b0);
    exp_q.push_back(8'hCA);
    do_ack(32'hCAFEF00D, 3);
    vecs.push_back('{8'h55, 1'b1, 8'hFE});
    vecs.push_back('{8'h55, 1'b1, 8'hF0});
    vecs.push_back('{8'h55, 1'b1, 8'h0D});
    vecs.push_back('{8'h55, 1'b0, 8'h00});
    run_vecs();
    wait_req();
    chk("rd2_addr", bif.bus_addr, RD2_ADDR);
    exp_q.push_back(8'h12);
    do_ack(32'h12345678, 1);
    frame_abort();

    // Out-of-range target: 0xEE then silence until the frame ends.
    req_allowed = 1'b0;
    vecs.push_back('{8'hF0, 1'b1, 8'hEE});
    vecs.push_back('{8'h12, 1'b0, 8'h00});
    vecs.push_back('{8'h34, 1'b0, 8'h00});
    run_vecs();
    frame_abort();
    req_allowed = 1'b1;

    // Next frame is decoded normally; abort it while the bus cycle is pending.
    vecs.push_back('{8'h30, 1'b1, 8'hCC});
    vecs.push_back('{8'h0A, 1'b1, 8'hAD});
    vecs.push_back('{8'h0B, 1'b1, 8'hAD});
    run_vecs();
    wait_req();
    chk("ab_sel", bif.bus_sel, 4'b1000);
    chk("ab_addr", bif.bus_addr, 20'h00A0B);
    bif.rx_rst = 1'b1;
    tick();
    bif.rx_rst = 1'b0;
    do_ack(32'hA5A5A5A5, 9);
    repeat (4) tick();

    // Reset in the middle of write data, then a clean frame from offset 0.
    vecs.push_back('{8'h85, 1'b1, 8'hCC});
    vecs.push_back('{8'h01, 1'b1, 8'hAD});
    vecs.push_back('{8'h02, 1'b1, 8'hAD});
    vecs.push_back('{8'h77, 1'b1, 8'hD0});
    vecs.push_back('{8'h88, 1'b1, 8'hD1});
    run_vecs();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    vecs.push_back('{8'h9F, 1'b1, 8'hCC});
    vecs.push_back('{8'hFF, 1'b1, 8'hAD});
    vecs.push_back('{8'hFF, 1'b1, 8'hAD});
    vecs.push_back('{8'h01, 1'b1, 8'hD0});
    vecs.push_back('{8'h02, 1'b1, 8'hD1});
    vecs.push_back('{8'h03, 1'b1, 8'hD2});
    vecs.push_back('{8'h04, 1'b1, 8'hD3});
    run_vecs();
    wait_req();
    chk("wr2_addr", bif.bus_addr, 20'hFFFFF);
    chk("wr2_wdata", bif.bus_wdata, 32'h01020304);
    do_ack(32'h0, 0);
    chk("wr2_addr_after_ack", bif.bus_addr, WRAP_ADDR);
    frame_abort();
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
